// File: rtl/radix_2_div_if.sv
// Request/result bundle between the MDU top and the radix-2 divider.
// The master side (MDU top) presents operands and the consumer stall.
// The slave side (divider) returns the result, its valid flag and busy.
interface radix_2_div_if;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_in_valid;
    logic [1:0]  div_type;
    logic        cpu_busy;
    logic [31:0] div_out;
    logic        div_out_valid;
    logic        div_busy;

    modport master (
        output dividend,
        output divisor,
        output div_in_valid,
        output div_type,
        output cpu_busy,
        input  div_out,
        input  div_out_valid,
        input  div_busy
    );

    modport slave (
        input  dividend,
        input  divisor,
        input  div_in_valid,
        input  div_type,
        input  cpu_busy,
        output div_out,
        output div_out_valid,
        output div_busy
    );
endinterface

// File: rtl/radix_2_div.sv
// Iterative RV32M divider/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per clock (32 iterations).
// Divide-by-zero and signed overflow bypass the iterations and finish
// in the acceptance cycle. The result is held in DONE while cpu_busy is high.
module radix_2_div (
    input  logic          clk,
    input  logic          rst,
    radix_2_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Operation context captured at acceptance
    logic        r_sel_rem;   // 1: return remainder, 0: return quotient
    logic        r_neg_q;     // quotient must be negated at the end
    logic        r_neg_r;     // remainder must be negated at the end

    // Iteration datapath
    logic [31:0] r_dvd;       // dividend magnitude, shifted out MSB first
    logic [31:0] r_dvs;       // divisor magnitude
    logic [31:0] r_rem;       // partial remainder (always < divisor)
    logic [31:0] r_quo;       // quotient being assembled
    logic [4:0]  r_cnt;       // iteration counter

    // Registered outputs
    logic [31:0] r_div_out;
    logic        r_div_out_valid;
    logic        r_div_busy;

    // Combinational helpers
    logic        w_signed_req;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_special;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_special_out;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_step;
    logic [31:0] w_quo_step;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;
    logic        w_accept;
    logic        w_last_iter;
    logic        w_busy_nxt;
    logic        w_valid_nxt;

    assign bus.div_out       = r_div_out;
    assign bus.div_out_valid = r_div_out_valid;
    assign bus.div_busy      = r_div_busy;

    // Request decode: operand magnitudes and single-cycle special results
    always_comb begin
        w_signed_req  = ~bus.div_type[0];
        w_div_zero    = (bus.divisor == 32'd0);
        w_overflow    = w_signed_req
                        && (bus.dividend == 32'h8000_0000)
                        && (bus.divisor  == 32'hFFFF_FFFF);
        w_special     = w_div_zero | w_overflow;
        w_dvd_mag     = bus.dividend;
        w_dvs_mag     = bus.divisor;
        w_special_out = 32'd0;
        if (w_signed_req && bus.dividend[31]) begin
            w_dvd_mag = 32'd0 - bus.dividend;
        end else begin
            w_dvd_mag = bus.dividend;
        end
        if (w_signed_req && bus.divisor[31]) begin
            w_dvs_mag = 32'd0 - bus.divisor;
        end else begin
            w_dvs_mag = bus.divisor;
        end
        // Divide-by-zero wins over overflow; overflow needs divisor = -1
        if (w_div_zero) begin
            w_special_out = bus.div_type[1] ? bus.dividend : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_special_out = bus.div_type[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            w_special_out = 32'd0;
        end
    end

    // One restoring step plus the sign-corrected final result
    always_comb begin
        w_shift = {r_rem, r_dvd[31]};
        w_diff  = w_shift - {1'b0, r_dvs};
        if (!w_diff[32]) begin
            w_rem_step = w_diff[31:0];
            w_quo_step = {r_quo[30:0], 1'b1};
        end else begin
            w_rem_step = w_shift[31:0];
            w_quo_step = {r_quo[30:0], 1'b0};
        end
        if (r_neg_q) begin
            w_quo_final = 32'd0 - w_quo_step;
        end else begin
            w_quo_final = w_quo_step;
        end
        if (r_neg_r) begin
            w_rem_final = 32'd0 - w_rem_step;
        end else begin
            w_rem_final = w_rem_step;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.div_in_valid) begin
                    w_state_nxt = w_special ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (!bus.cpu_busy) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: status flags follow the state being entered
    always_comb begin
        w_accept    = (r_state == IDLE) && bus.div_in_valid;
        w_last_iter = (r_state == CALC) && (r_cnt == 5'd31);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_valid_nxt = (w_state_nxt == DONE);
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_out_valid <= 1'b0;
            r_div_busy      <= 1'b0;
        end else begin
            r_div_out_valid <= w_valid_nxt;
            r_div_busy      <= w_busy_nxt;
        end
    end

    // Datapath: operand capture, iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dvd     <= 32'd0;
            r_dvs     <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_cnt     <= 5'd0;
            r_div_out <= 32'd0;
        end else if (w_accept) begin
            r_sel_rem <= bus.div_type[1];
            r_neg_q   <= w_signed_req && (bus.dividend[31] ^ bus.divisor[31]);
            r_neg_r   <= w_signed_req && bus.dividend[31];
            r_dvd     <= w_dvd_mag;
            r_dvs     <= w_dvs_mag;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_cnt     <= 5'd0;
            if (w_special) begin
                r_div_out <= w_special_out;
            end else begin
                r_div_out <= r_div_out;
            end
        end else if (r_state == CALC) begin
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + 5'd1;
            if (w_last_iter) begin
                r_div_out <= r_sel_rem ? w_rem_final : w_quo_final;
            end else begin
                r_div_out <= r_div_out;
            end
        end else begin
            r_div_out <= r_div_out;
        end
    end

endmodule

// File: tb/tb_radix_2_div.sv
// Directed self-checking bench for radix_2_div.
module tb_radix_2_div;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    radix_2_div_if u_if ();

    radix_2_div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges from acceptance to valid, check result,
    // optionally hold it with cpu_busy and inject an ignored request.
    task automatic run_op(input string tag, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_k,
                          input int hold, input bit inject);
        int   k;
        logic busy_ok;
        @(negedge clk);
        u_if.dividend     = a;
        u_if.divisor      = b;
        u_if.div_type     = t;
        u_if.div_in_valid = 1'b1;
        u_if.cpu_busy     = (hold > 0);
        @(posedge clk);
        #1;
        u_if.div_in_valid = 1'b0;
        u_if.dividend     = 32'h1234_5678;
        u_if.divisor      = 32'h0000_0003;
        u_if.div_type     = ~t;
        k       = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!u_if.div_out_valid && k < 100) begin
            if (!u_if.div_busy) busy_ok = 1'b0;
            if (inject && k == 5) begin
                u_if.dividend     = 32'd50;
                u_if.divisor      = 32'd5;
                u_if.div_type     = 2'b01;
                u_if.div_in_valid = 1'b1;
            end else begin
                u_if.div_in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        u_if.div_in_valid = 1'b0;
        check({tag, " latency"}, k, exp_k);
        check({tag, " busy_calc"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " result"}, u_if.div_out, exp);
        check({tag, " busy_done"}, {31'd0, u_if.div_busy}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold_valid"}, {31'd0, u_if.div_out_valid}, 32'd1);
            check({tag, " hold_out"}, u_if.div_out, exp);
        end
        u_if.cpu_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " valid_fall"}, {31'd0, u_if.div_out_valid}, 32'd0);
        check({tag, " busy_fall"}, {31'd0, u_if.div_busy}, 32'd0);
        check({tag, " out_kept"}, u_if.div_out, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst               = 1'b1;
        u_if.dividend     = 32'd0;
        u_if.divisor      = 32'd0;
        u_if.div_type     = 2'b00;
        u_if.div_in_valid = 1'b0;
        u_if.cpu_busy     = 1'b0;
        #12;
        check("reset out", u_if.div_out, 32'd0);
        check("reset valid", {31'd0, u_if.div_out_valid}, 32'd0);
        check("reset busy", {31'd0, u_if.div_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("DIV 100/7",     2'b00, 32'd100,        32'd7,          32'd14,         32, 0, 1'b0);
        run_op("REM 100%7",     2'b10, 32'd100,        32'd7,          32'd2,          32, 0, 1'b0);
        run_op("REM -7%2",      2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, 0, 1'b0);
        run_op("DIV -7/2",      2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, 0, 1'b0);
        run_op("DIVU max/1",    2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32, 0, 1'b0);
        run_op("REMU max/16",   2'b11, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  32, 0, 1'b0);
        run_op("DIV 5/0",       2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  0, 1'b0);
        run_op("REMU 5/0",      2'b11, 32'd5,          32'd0,          32'd5,          0,  0, 1'b0);
        run_op("DIV ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  0, 1'b0);
        run_op("REM ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  0, 1'b0);
        run_op("DIV hold+inj",  2'b00, 32'd100,        32'd7,          32'd14,         32, 5, 1'b1);

        // Mid-CALC asynchronous reset: outputs clear before the next edge
        @(negedge clk);
        u_if.dividend     = 32'd1000;
        u_if.divisor      = 32'd3;
        u_if.div_type     = 2'b01;
        u_if.div_in_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-reset busy", {31'd0, u_if.div_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("async rst out", u_if.div_out, 32'd0);
        check("async rst valid", {31'd0, u_if.div_out_valid}, 32'd0);
        check("async rst busy", {31'd0, u_if.div_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset valid", {31'd0, u_if.div_out_valid}, 32'd0);

        run_op("DIVU 9/3",      2'b01, 32'd9,          32'd3,          32'd3,          32, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
